// File: rtl/gpu_pkg.sv
// Shared definitions for the line rasterizer: FSM encoding, default screen
// geometry and common colour values.
package gpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } gpu_state_e;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;

    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] BLACK = 16'h0000;

endpackage

// File: rtl/SevenSeg.sv
// Hex nibble to seven-segment decoder, active-low segments ordered gfedcba.
module SevenSeg (
    input  logic [3:0] I_HEX,
    output logic [6:0] O_SEG
);

    always_comb begin
        O_SEG = 7'h7F;
        case (I_HEX)
            4'h0: O_SEG = 7'h40;
            4'h1: O_SEG = 7'h79;
            4'h2: O_SEG = 7'h24;
            4'h3: O_SEG = 7'h30;
            4'h4: O_SEG = 7'h19;
            4'h5: O_SEG = 7'h12;
            4'h6: O_SEG = 7'h02;
            4'h7: O_SEG = 7'h78;
            4'h8: O_SEG = 7'h00;
            4'h9: O_SEG = 7'h10;
            4'hA: O_SEG = 7'h08;
            4'hB: O_SEG = 7'h03;
            4'hC: O_SEG = 7'h46;
            4'hD: O_SEG = 7'h21;
            4'hE: O_SEG = 7'h06;
            4'hF: O_SEG = 7'h0E;
            default: O_SEG = 7'h7F;
        endcase
    end

endmodule

// File: rtl/gpu_line_step.sv
// Combinational Bresenham step: advances (x,y,err) by one pixel and flags
// when the current point is the line's end point.
module gpu_line_step #(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0]        i_x,
    input  logic [COORD_W-1:0]        i_y,
    input  logic [COORD_W-1:0]        i_x1,
    input  logic [COORD_W-1:0]        i_y1,
    input  logic [COORD_W-1:0]        i_dx,
    input  logic [COORD_W-1:0]        i_dy,
    input  logic signed [COORD_W+1:0] i_err,
    input  logic                      i_sx_neg,
    input  logic                      i_sy_neg,
    output logic [COORD_W-1:0]        o_x,
    output logic [COORD_W-1:0]        o_y,
    output logic signed [COORD_W+1:0] o_err,
    output logic                      o_at_end
);

    localparam int EW = COORD_W + 2;
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    // One extra bit so that 2*err and the running sum never overflow.
    logic signed [EW:0] e2;
    logic signed [EW:0] dx_s;
    logic signed [EW:0] dy_s;
    logic signed [EW:0] err_acc;

    always_comb begin
        e2       = {i_err, 1'b0};
        dx_s     = $signed({3'b000, i_dx});
        dy_s     = $signed({3'b000, i_dy});
        err_acc  = {i_err[EW-1], i_err};
        o_x      = i_x;
        o_y      = i_y;
        o_at_end = (i_x == i_x1) && (i_y == i_y1);

        // Both tests use the pre-step error term.
        if (e2 > -dy_s) begin
            err_acc = err_acc - dy_s;
            o_x     = i_sx_neg ? (i_x - ONE) : (i_x + ONE);
        end
        if (e2 < dx_s) begin
            err_acc = err_acc + dx_s;
            o_y     = i_sy_neg ? (i_y - ONE) : (i_y + ONE);
        end
        o_err = err_acc[EW-1:0];
    end

endmodule

// File: rtl/gpu_line_raster.sv
// All-octant Bresenham line rasterizer streaming clipped pixel writes into the
// framebuffer while video is blanked. GPU_LINE_SSEG_EN adds a hex pixel-count display.
module gpu_line_raster
    import gpu_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int COORD_W  = 10,
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16
) (
    input  logic               I_CLK,
    input  logic               I_RST_N,
    input  logic               I_VIDEO_ON,
    input  logic               I_CMD_VALID,
    output logic               O_CMD_READY,
    input  logic [COORD_W-1:0] I_X0,
    input  logic [COORD_W-1:0] I_Y0,
    input  logic [COORD_W-1:0] I_X1,
    input  logic [COORD_W-1:0] I_Y1,
    input  logic [DATA_W-1:0]  I_COLOR,
    output logic [ADDR_W-1:0]  O_GPU_ADDR,
    output logic [DATA_W-1:0]  O_GPU_DATA,
    output logic               O_GPU_WRITE,
    output logic               O_GPU_READ,
    output logic               O_BUSY,
    output logic               O_DONE,
    output logic [COORD_W:0]   O_PIX_COUNT,
    output logic [6:0]         O_HEX0,
    output logic [6:0]         O_HEX1,
    output logic [6:0]         O_HEX2,
    output logic [6:0]         O_HEX3,
    output logic [1:0]         O_DBG_STATE
);

    // Command handshake: a line is accepted on a rising edge where
    // I_CMD_VALID and O_CMD_READY are both high; O_CMD_READY is high only in IDLE.

    localparam int EW = COORD_W + 2;

    gpu_state_e state_q, state_d;

    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0]   x1_q, x1_d, y1_q, y1_d;
    logic [COORD_W-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic signed [EW-1:0] err_q, err_d;
    logic [DATA_W-1:0]    color_q, color_d;
    logic [COORD_W:0]     cnt_q, cnt_d;

    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 write_q, write_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;
    logic [COORD_W:0]     pix_q, pix_d;

    logic [COORD_W-1:0]   step_x, step_y;
    logic signed [EW-1:0] step_err;
    logic                 at_end;
    logic                 on_screen;

    gpu_line_step #(
        .COORD_W (COORD_W)
    ) u_step (
        .i_x      (x_q),
        .i_y      (y_q),
        .i_x1     (x1_q),
        .i_y1     (y1_q),
        .i_dx     (dx_q),
        .i_dy     (dy_q),
        .i_err    (err_q),
        .i_sx_neg (sx_neg_q),
        .i_sy_neg (sy_neg_q),
        .o_x      (step_x),
        .o_y      (step_y),
        .o_err    (step_err),
        .o_at_end (at_end)
    );

    assign on_screen = (32'(x_q) < 32'(SCREEN_W)) && (32'(y_q) < 32'(SCREEN_H));

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;
        color_d  = color_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        write_d  = 1'b0;
        done_d   = 1'b0;
        pix_d    = pix_q;

        case (state_q)
            ST_IDLE: begin
                if (I_CMD_VALID && ready_q) begin
                    x_d     = I_X0;
                    y_d     = I_Y0;
                    x1_d    = I_X1;
                    y1_d    = I_Y1;
                    color_d = I_COLOR;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                dx_d     = (x1_q >= x_q) ? (x1_q - x_q) : (x_q - x1_q);
                dy_d     = (y1_q >= y_q) ? (y1_q - y_q) : (y_q - y1_q);
                sx_neg_d = (x1_q < x_q);
                sy_neg_d = (y1_q < y_q);
                err_d    = $signed({2'b00, dx_d}) - $signed({2'b00, dy_d});
                cnt_d    = '0;
                state_d  = ST_DRAW;
            end
            ST_DRAW: begin
                // While video is on, everything holds so no pixel is skipped or repeated.
                if (!I_VIDEO_ON) begin
                    if (on_screen) begin
                        addr_d  = ADDR_W'(32'(y_q) * 32'(SCREEN_W) + 32'(x_q));
                        data_d  = color_q;
                        write_d = 1'b1;
                        cnt_d   = cnt_q + (COORD_W+1)'(1);
                    end
                    if (at_end) begin
                        state_d = ST_DONE;
                    end else begin
                        x_d   = step_x;
                        y_d   = step_y;
                        err_d = step_err;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                pix_d   = cnt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
            color_q  <= DATA_W'(BLACK);
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            pix_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            err_q    <= err_d;
            color_q  <= color_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            write_q  <= write_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            pix_q    <= pix_d;
        end
    end

    assign O_CMD_READY = ready_q;
    assign O_GPU_ADDR  = addr_q;
    assign O_GPU_DATA  = data_q;
    assign O_GPU_WRITE = write_q;
    assign O_GPU_READ  = 1'b0;
    assign O_BUSY      = busy_q;
    assign O_DONE      = done_q;
    assign O_PIX_COUNT = pix_q;
    assign O_DBG_STATE = state_q;

`ifdef GPU_LINE_SSEG_EN
    logic [15:0] cnt_hex;
    assign cnt_hex = 16'(pix_q);

    SevenSeg u_seg0 (.I_HEX(cnt_hex[3:0]),   .O_SEG(O_HEX0));
    SevenSeg u_seg1 (.I_HEX(cnt_hex[7:4]),   .O_SEG(O_HEX1));
    SevenSeg u_seg2 (.I_HEX(cnt_hex[11:8]),  .O_SEG(O_HEX2));
    SevenSeg u_seg3 (.I_HEX(cnt_hex[15:12]), .O_SEG(O_HEX3));
`else
    assign O_HEX0 = 7'h7F;
    assign O_HEX1 = 7'h7F;
    assign O_HEX2 = 7'h7F;
    assign O_HEX3 = 7'h7F;
`endif

endmodule

// File: tb/tb_gpu_line_raster.sv
// Directed and randomized bench for gpu_line_raster against a textbook
// Bresenham reference model with a scoreboard of expected writes.
module tb_gpu_line_raster;
  import gpu_pkg::*;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;
  localparam int ADDR_W   = 18;
  localparam int DATA_W   = 16;
  localparam int BUDGET   = 3000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               video_on = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [COORD_W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [DATA_W-1:0]  color = '0;
  logic [ADDR_W-1:0]  gpu_addr;
  logic [DATA_W-1:0]  gpu_data;
  logic               gpu_write, gpu_read, busy, done;
  logic [COORD_W:0]   pix_count;
  logic [6:0]         hex0, hex1, hex2, hex3;
  logic [1:0]         dbg_state;

  gpu_line_raster #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .COORD_W  (COORD_W),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .I_CLK       (clk),
    .I_RST_N     (rst_n),
    .I_VIDEO_ON  (video_on),
    .I_CMD_VALID (cmd_valid),
    .O_CMD_READY (cmd_ready),
    .I_X0        (x0),
    .I_Y0        (y0),
    .I_X1        (x1),
    .I_Y1        (y1),
    .I_COLOR     (color),
    .O_GPU_ADDR  (gpu_addr),
    .O_GPU_DATA  (gpu_data),
    .O_GPU_WRITE (gpu_write),
    .O_GPU_READ  (gpu_read),
    .O_BUSY      (busy),
    .O_DONE      (done),
    .O_PIX_COUNT (pix_count),
    .O_HEX0      (hex0),
    .O_HEX1      (hex1),
    .O_HEX2      (hex2),
    .O_HEX3      (hex3),
    .O_DBG_STATE (dbg_state)
  );

  // scoreboard
  logic [ADDR_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_d_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: textbook Bresenham over plain integers, clipped to the screen.
  task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input logic [DATA_W-1:0] col,
                            output int npix, output int nvis,
                            output int first_vis_idx, output bit last_vis);
    int dx, dy, sx, sy, err, e2, x, y;
    bit vis;
    dx = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
    sx = (ax1 >= ax0) ? 1 : -1;
    sy = (ay1 >= ay0) ? 1 : -1;
    err = dx - dy;
    x = ax0;
    y = ay0;
    npix = 0;
    nvis = 0;
    first_vis_idx = -1;
    last_vis = 1'b0;
    while (1) begin
      vis = (x < SCREEN_W) && (y < SCREEN_H);
      if (vis) begin
        exp_q.push_back(ADDR_W'(y * SCREEN_W + x));
        exp_d_q.push_back(col);
        if (first_vis_idx < 0) first_vis_idx = npix;
        nvis++;
      end
      npix++;
      if (x == ax1 && y == ay1) begin
        last_vis = vis;
        break;
      end
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += sx; end
      if (e2 < dx)  begin err += dx; y += sy; end
    end
  endtask

  // driver + monitor for one full line command
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input logic [DATA_W-1:0] col,
                          input int stall_after, input int stall_len);
    int npix, nvis, first_idx, nw, cyc, first_cyc, last_w, done_cyc, stall_rem, exp_done;
    bit last_vis, stall_used, prev_video, got_done;
    exp_q.delete();
    exp_d_q.delete();
    model_line(ax0, ay0, ax1, ay1, col, npix, nvis, first_idx, last_vis);

    @(negedge clk);
    check("ready_before_cmd", 32'(cmd_ready), 1);
    x0 = COORD_W'(ax0); y0 = COORD_W'(ay0);
    x1 = COORD_W'(ax1); y1 = COORD_W'(ay1);
    color = col;
    cmd_valid = 1'b1;
    @(posedge clk);

    nw = 0; first_cyc = -1; last_w = -1; done_cyc = -1;
    stall_rem = 0; stall_used = 1'b0; prev_video = 1'b0; got_done = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      cyc = c;
      if (c == 0) begin
        check("ready_low_after_accept", 32'(cmd_ready), 0);
        check("busy_after_accept", 32'(busy), 1);
        // a second command while busy must be ignored
        x0 = 10'd300; y0 = 10'd300; x1 = 10'd310; y1 = 10'd305;
        color = ~col;
      end
      if (c == 2) cmd_valid = 1'b0;

      if (gpu_write === 1'b1) begin
        nw++;
        if (first_cyc < 0) first_cyc = cyc;
        last_w = cyc;
        if (prev_video) check("write_during_stall", 32'(gpu_write), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(gpu_addr), 32'hFFFF_FFFF);
        end else begin
          check("pixel_addr", 32'(gpu_addr), 32'(exp_q.pop_front()));
          check("pixel_data", 32'(gpu_data), 32'(exp_d_q.pop_front()));
        end
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        got_done = 1'b1;
        check("no_write_with_done", 32'(gpu_write), 0);
        check("idle_ready_at_done", 32'(cmd_ready), 1);
        check("not_busy_at_done", 32'(busy), 0);
        break;
      end

      if (stall_rem > 0) begin
        stall_rem--;
        if (stall_rem == 0) video_on = 1'b0;
      end else if (!stall_used && stall_len > 0 && nw == stall_after && nw < nvis) begin
        video_on = 1'b1;
        stall_rem = stall_len;
        stall_used = 1'b1;
      end
      prev_video = video_on;
    end
    video_on = 1'b0;
    cmd_valid = 1'b0;

    check("done_seen", 32'(got_done), 1);
    check("write_count", 32'(nw), 32'(nvis));
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    check("pix_count", 32'(pix_count), 32'(nvis));
    check("read_low", 32'(gpu_read), 0);
    exp_done = 2 + npix + (stall_used ? stall_len : 0);
    check("done_cycle", 32'(done_cyc), 32'(exp_done));
    if (first_idx >= 0) check("first_write_latency", 32'(first_cyc), 32'(2 + first_idx));
    if (last_vis) check("done_after_last_write", 32'(done_cyc), 32'(last_w + 1));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    int rx0, ry0, rx1, ry1;

    // reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", 32'(gpu_addr), 0);
    check("rst_data", 32'(gpu_data), 0);
    check("rst_write", 32'(gpu_write), 0);
    check("rst_read", 32'(gpu_read), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pix_count", 32'(pix_count), 0);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
`ifndef GPU_LINE_SSEG_EN
    check("hex_blank", {4'h0, hex3, hex2, hex1, hex0}, {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h7F});
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed lines
    run_line(0, 0, 3, 0, WHITE, 0, 0);
    run_line(2, 5, 2, 2, 16'h1234, 0, 0);
    run_line(0, 0, 2, 2, 16'hABCD, 0, 0);
    run_line(2, 0, 0, 1, 16'h0F0F, 0, 0);
    run_line(0, 0, 7, 0, WHITE, 3, 5);
    run_line(638, 0, 641, 0, 16'h5555, 0, 0);
    run_line(7, 7, 7, 7, 16'h00FF, 0, 0);
    run_line(635, 470, 645, 490, 16'h7777, 1, 2);

    // randomized lines in every octant, some crossing the clip edges
    for (int i = 0; i < 10; i++) begin
      rx0 = $urandom_range(0, 700);
      ry0 = $urandom_range(0, 520);
      rx1 = rx0 + $urandom_range(0, 40) - 20;
      ry1 = ry0 + $urandom_range(0, 40) - 20;
      if (rx1 < 0) rx1 = 0;
      if (ry1 < 0) ry1 = 0;
      run_line(rx0, ry0, rx1, ry1, DATA_W'($urandom), $urandom_range(1, 4), $urandom_range(0, 3));
    end

    // reset in the middle of a long line
    @(negedge clk);
    x0 = 10'd0; y0 = 10'd10; x1 = 10'd99; y1 = 10'd10;
    color = WHITE;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("midline_writing", 32'(gpu_write), 1);
    rst_n = 1'b0;
    #1;
    check("abort_write", 32'(gpu_write), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_abort_no_write", 32'(gpu_write), 0);
    end
    check("post_abort_ready", 32'(cmd_ready), 1);
    check("post_abort_state", 32'(dbg_state), 32'(ST_IDLE));

    // a line still runs normally after the abort
    run_line(1, 1, 4, 3, 16'h4321, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
